// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter (dmem_arbiter).
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int LAT_W      = 3;
  localparam int BURST_W    = 4;
  localparam int STAT_W     = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_LDR  = 1'b1
  } owner_t;

  // Event counters hold at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value,
                                                input logic              en);
    if (en && (value != {STAT_W{1'b1}})) begin
      return value + 1'b1;
    end
    return value;
  endfunction

endpackage

// File: rtl/dmem_rd_tracker.sv
// Follows one outstanding RAM read: counts down the fixed read latency and
// raises a one-cycle completion pulse toward whichever requester owns it.
module dmem_rd_tracker
  import dmem_arb_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  owner_t start_owner,
  output logic   core_done,
  output logic   ldr_done,
  output logic   busy
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LAT);

  logic [LAT_W-1:0] lat_cnt;
  owner_t           owner;
  logic             done;

  // The count reaches 1 exactly READ_LAT cycles after the issue cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt <= '0;
      owner   <= OWN_CORE;
    end else if (start) begin
      lat_cnt <= LAT_LOAD;
      owner   <= start_owner;
    end else if (lat_cnt != '0) begin
      lat_cnt <= lat_cnt - 1'b1;
    end
  end

  assign busy      = (lat_cnt != '0);
  assign done      = !rst && (lat_cnt == LAT_W'(1));
  assign core_done = done && (owner == OWN_CORE);
  assign ldr_done  = done && (owner == OWN_LDR);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: core MEM stage has priority, the loader
// is guaranteed a slot after CORE_BURST core grants. Optional counters: DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int READ_LAT   = 1,
  parameter int CORE_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_ce_i,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [DATA_W-1:0] c_wdata_i,
  output logic [DATA_W-1:0] c_rdata_o,
  output logic              c_ack_o,
  output logic              c_stall_o,
  input  logic              l_valid_i,
  input  logic              l_we_i,
  input  logic [ADDR_W-1:0] l_addr_i,
  input  logic [DATA_W-1:0] l_wdata_i,
  output logic              l_ready_o,
  output logic              l_rvalid_o,
  output logic [DATA_W-1:0] l_rdata_o,
  output logic              m_ce_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic [DATA_W-1:0] m_rdata_i
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] core_grants_o,
  output logic [STAT_W-1:0] ldr_grants_o,
  output logic [STAT_W-1:0] stall_cycles_o
`endif
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(CORE_BURST);

  state_t             state_q;
  state_t             state_d;
  logic [BURST_W-1:0] burst_cnt;
  logic               burst_full;
  logic               ldr_win;
  logic               core_win;
  logic               issue;
  logic               issue_we;
  logic               rd_start;
  owner_t             rd_owner;
  logic               core_done;
  logic               ldr_done;
  logic               rd_busy;

  assign burst_full = (burst_cnt == BURST_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration only happens in IDLE; RD_WAIT just waits for the tracker.
  always_comb begin
    state_d  = state_q;
    ldr_win  = 1'b0;
    core_win = 1'b0;
    issue    = 1'b0;
    issue_we = 1'b0;
    rd_owner = OWN_CORE;
    case (state_q)
      IDLE: begin
        if (!rst) begin
          ldr_win  = l_valid_i && (!c_ce_i || burst_full);
          core_win = c_ce_i && !ldr_win;
          issue    = ldr_win || core_win;
          issue_we = ldr_win ? l_we_i : (core_win && c_we_i);
          rd_owner = ldr_win ? OWN_LDR : OWN_CORE;
          if (issue && !issue_we) begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (core_done || ldr_done || !rd_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_start = issue && !issue_we;

  // The loader's guaranteed slot: count core wins only while it is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (ldr_win || !l_valid_i) begin
      burst_cnt <= '0;
    end else if (core_win && !burst_full) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  dmem_rd_tracker #(
    .READ_LAT (READ_LAT)
  ) u_rd_tracker (
    .clk         (clk),
    .rst         (rst),
    .start       (rd_start),
    .start_owner (rd_owner),
    .core_done   (core_done),
    .ldr_done    (ldr_done),
    .busy        (rd_busy)
  );

  always_comb begin
    m_ce_o    = issue;
    m_we_o    = issue_we;
    m_addr_o  = '0;
    m_wdata_o = '0;
    if (ldr_win) begin
      m_addr_o  = l_addr_i;
      m_wdata_o = l_wdata_i;
    end else if (core_win) begin
      m_addr_o  = c_addr_i;
      m_wdata_o = c_wdata_i;
    end
  end

  // Writes acknowledge in the issue cycle, reads when the tracker completes.
  assign c_ack_o    = (core_win && c_we_i) || core_done;
  assign c_stall_o  = c_ce_i && !c_ack_o;
  assign c_rdata_o  = core_done ? m_rdata_i : '0;
  assign l_ready_o  = ldr_win;
  assign l_rvalid_o = ldr_done;
  assign l_rdata_o  = ldr_done ? m_rdata_i : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] core_grants_q;
  logic [STAT_W-1:0] ldr_grants_q;
  logic [STAT_W-1:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      core_grants_q  <= '0;
      ldr_grants_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      core_grants_q  <= sat_inc(core_grants_q, core_win);
      ldr_grants_q   <= sat_inc(ldr_grants_q, ldr_win);
      stall_cycles_q <= sat_inc(stall_cycles_q, c_stall_o);
    end
  end

  assign core_grants_o  = rst ? '0 : core_grants_q;
  assign ldr_grants_o   = rst ? '0 : ldr_grants_q;
  assign stall_cycles_o = rst ? '0 : stall_cycles_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// checked every cycle against a cycle-count based reference model.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CB = 4;
`ifdef DMEM_ARB_STATS_EN
  localparam int RL = 7;
`else
  localparam int RL = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          c_ce_i, c_we_i, c_ack_o, c_stall_o;
  logic [AW-1:0] c_addr_i, l_addr_i, m_addr_o;
  logic [DW-1:0] c_wdata_i, c_rdata_o, l_wdata_i, l_rdata_o, m_wdata_o, m_rdata_i;
  logic          l_valid_i, l_we_i, l_ready_o, l_rvalid_o, m_ce_o, m_we_o;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   core_grants_o, ldr_grants_o, stall_cycles_o;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W (AW), .DATA_W (DW), .READ_LAT (RL), .CORE_BURST (CB)
  ) dut (
    .clk (clk), .rst (rst),
    .c_ce_i (c_ce_i), .c_we_i (c_we_i), .c_addr_i (c_addr_i), .c_wdata_i (c_wdata_i),
    .c_rdata_o (c_rdata_o), .c_ack_o (c_ack_o), .c_stall_o (c_stall_o),
    .l_valid_i (l_valid_i), .l_we_i (l_we_i), .l_addr_i (l_addr_i), .l_wdata_i (l_wdata_i),
    .l_ready_o (l_ready_o), .l_rvalid_o (l_rvalid_o), .l_rdata_o (l_rdata_o),
    .m_ce_o (m_ce_o), .m_we_o (m_we_o), .m_addr_o (m_addr_o), .m_wdata_o (m_wdata_o),
    .m_rdata_i (m_rdata_i)
`ifdef DMEM_ARB_STATS_EN
    ,
    .core_grants_o (core_grants_o), .ldr_grants_o (ldr_grants_o),
    .stall_cycles_o (stall_cycles_o)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
  endtask

  // RAM environment: 16 words, reads return RL cycles after issue, noise otherwise.
  typedef struct { int due; logic [31:0] data; } rd_ret_t;
  rd_ret_t     ram_q[$];
  logic [31:0] ram[16];

  // Reference model: memory image, pending read as (issue cycle, owner, data).
  logic [31:0] mdl_mem[16];
  int          cyc = 0;
  int          burst = 0;
  bit          rd_pend = 0;
  int          rd_cyc = 0;
  bit          rd_ldr = 0;
  logic [31:0] rd_data = '0;
  int          mdl_cgr = 0, mdl_lgr = 0, mdl_stall = 0;
  bit          last_core_ack = 0, last_ldr_acc = 0;
  bit          log_grants = 0;
  logic [31:0] grant_bits = '0;
  int          grant_n = 0;

  function automatic int sat16(input int v, input bit en);
    return (en && v < 65535) ? v + 1 : v;
  endfunction

  task automatic evalCycle();
    bit          e_issue, e_lwin, e_we, e_cack, e_lrv, e_stall;
    logic [31:0] e_addr, e_wd, e_crd, e_lrd;
    rd_ret_t     r;
    if (ram_q.size() > 0 && ram_q[0].due == cyc) begin
      r = ram_q.pop_front();
      m_rdata_i = r.data;
    end else begin
      m_rdata_i = $urandom;
    end
    #1;
    e_issue = 0; e_lwin = 0; e_we = 0; e_cack = 0; e_lrv = 0;
    e_addr = '0; e_wd = '0; e_crd = '0; e_lrd = '0;
    if (!rst) begin
      if (rd_pend) begin
        if (cyc - rd_cyc == RL) begin
          if (rd_ldr) begin e_lrv = 1; e_lrd = rd_data; end
          else begin e_cack = 1; e_crd = rd_data; end
        end
      end else if (c_ce_i || l_valid_i) begin
        e_issue = 1;
        e_lwin  = l_valid_i && (!c_ce_i || burst >= CB);
        e_we    = e_lwin ? l_we_i : c_we_i;
        e_addr  = e_lwin ? l_addr_i : c_addr_i;
        e_wd    = e_lwin ? l_wdata_i : c_wdata_i;
        e_cack  = !e_lwin && c_we_i;
      end
    end
    e_stall = c_ce_i && !e_cack;

    checkOutput("m_ce", m_ce_o, e_issue);
    checkOutput("m_we", m_we_o, e_we);
    checkOutput("c_ack", c_ack_o, e_cack);
    checkOutput("c_stall", c_stall_o, e_stall);
    checkOutput("l_ready", l_ready_o, e_issue && e_lwin);
    checkOutput("l_rvalid", l_rvalid_o, e_lrv);
    checkOutput("c_rdata", c_rdata_o, e_crd);
    checkOutput("l_rdata", l_rdata_o, e_lrd);
    if (rst || e_issue) begin
      checkOutput("m_addr", m_addr_o, e_addr);
      checkOutput("m_wdata", m_wdata_o, e_wd);
    end
`ifdef DMEM_ARB_STATS_EN
    checkOutput("core_grants", core_grants_o, rst ? 0 : mdl_cgr);
    checkOutput("ldr_grants", ldr_grants_o, rst ? 0 : mdl_lgr);
    checkOutput("stall_cycles", stall_cycles_o, rst ? 0 : mdl_stall);
`endif

    if (m_ce_o) begin
      if (m_we_o) ram[m_addr_o[5:2]] = m_wdata_o;
      else ram_q.push_back('{cyc + RL, ram[m_addr_o[5:2]]});
    end
    if (log_grants && m_ce_o) begin
      grant_bits = {grant_bits[30:0], l_ready_o};
      grant_n++;
    end

    if (rst) begin
      rd_pend = 0; burst = 0; mdl_cgr = 0; mdl_lgr = 0; mdl_stall = 0;
    end else begin
      if (rd_pend && cyc - rd_cyc == RL) rd_pend = 0;
      if (e_issue) begin
        if (e_we) mdl_mem[e_addr[5:2]] = e_wd;
        else begin
          rd_pend = 1; rd_cyc = cyc; rd_ldr = e_lwin; rd_data = mdl_mem[e_addr[5:2]];
        end
      end
      if (!l_valid_i || (e_issue && e_lwin)) burst = 0;
      else if (e_issue) burst = (burst < CB) ? burst + 1 : CB;
      mdl_cgr   = sat16(mdl_cgr, e_issue && !e_lwin);
      mdl_lgr   = sat16(mdl_lgr, e_issue && e_lwin);
      mdl_stall = sat16(mdl_stall, e_stall);
    end
    last_core_ack = e_cack;
    last_ldr_acc  = e_issue && e_lwin;
    cyc++;
  endtask

  task automatic applyStimulus(input bit r,
                               input bit ce, input bit we, input logic [31:0] addr,
                               input logic [31:0] wd,
                               input bit lv, input bit lwe, input logic [31:0] laddr,
                               input logic [31:0] lwd);
    @(negedge clk);
    rst = r;
    c_ce_i = ce; c_we_i = we; c_addr_i = addr; c_wdata_i = wd;
    l_valid_i = lv; l_we_i = lwe; l_addr_i = laddr; l_wdata_i = lwd;
    evalCycle();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Requesters keep their fields until accepted, then pick a fresh request.
  task automatic randomStep(input int core_pct, input int ldr_pct);
    bit          ce, we, lv, lwe;
    logic [31:0] a, wd, la, lwd;
    ce = c_ce_i; we = c_we_i; a = c_addr_i; wd = c_wdata_i;
    lv = l_valid_i; lwe = l_we_i; la = l_addr_i; lwd = l_wdata_i;
    if (!c_ce_i || last_core_ack) begin
      ce = ($urandom_range(99) < core_pct);
      we = $urandom_range(1);
      a  = 32'($urandom_range(15)) << 2;
      wd = $urandom;
    end
    if (!l_valid_i || last_ldr_acc) begin
      lv  = ($urandom_range(99) < ldr_pct);
      lwe = $urandom_range(1);
      la  = 32'($urandom_range(15)) << 2;
      lwd = $urandom;
    end
    applyStimulus(0, ce, we, a, wd, lv, lwe, la, lwd);
  endtask

  int lat, n_ack, n_rv, n_rdy;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i] = $urandom;
      mdl_mem[i] = ram[i];
    end
    rst = 1; c_ce_i = 0; c_we_i = 0; c_addr_i = '0; c_wdata_i = '0;
    l_valid_i = 0; l_we_i = 0; l_addr_i = '0; l_wdata_i = '0; m_rdata_i = '0;

    // Reset with requests present: everything quiet, stall mirrors c_ce_i.
    applyStimulus(1, 1, 1, 32'h10, 32'h1, 1, 1, 32'h20, 32'h2);
    applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, '0);
    idleCycle();

    // Core store then load of the same word.
    applyStimulus(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, '0, '0);
    checkOutput("sw_ack", c_ack_o, 1);
    applyStimulus(0, 1, 0, 32'h10, '0, 0, 0, '0, '0);
    lat = 0;
    while (!c_ack_o && lat < RL + 3) begin
      applyStimulus(0, 1, 0, 32'h10, '0, 0, 0, '0, '0);
      lat++;
    end
    checkOutput("lw_latency", lat, RL);
    checkOutput("lw_data", c_rdata_o, 32'hDEADBEEF);
    idleCycle();

    // Loader write then read back.
    applyStimulus(0, 0, 0, '0, '0, 1, 1, 32'h20, 32'h12345678);
    checkOutput("ldr_wr_ready", l_ready_o, 1);
    applyStimulus(0, 0, 0, '0, '0, 1, 0, 32'h20, '0);
    checkOutput("ldr_rd_ready", l_ready_o, 1);
    lat = 0; n_ack = 0;
    while (!l_rvalid_o && lat < RL + 3) begin
      idleCycle();
      n_ack += int'(c_ack_o);
      lat++;
    end
    checkOutput("ldr_rd_latency", lat, RL);
    checkOutput("ldr_rd_data", l_rdata_o, 32'h12345678);
    checkOutput("ldr_rd_no_core_ack", n_ack, 0);
    idleCycle();

    // Both requesting continuously: four core grants, then one loader grant.
    grant_bits = '0; grant_n = 0; log_grants = 1;
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 1, 1, 32'h30, 32'hC0DE0000, 1, 1, 32'h3C, 32'hA5A5A5A5);
    log_grants = 0;
    checkOutput("grant_order", grant_bits[9:0], 32'b0000100001);
    checkOutput("grant_count", grant_n, 10);
    idleCycle();

    // Loader arrives while a core read is outstanding.
    applyStimulus(0, 1, 0, 32'h30, '0, 0, 0, '0, '0);
    n_ack = 0; n_rv = 0; n_rdy = 0;
    for (int i = 0; i < RL; i++) begin
      applyStimulus(0, !last_core_ack, 0, 32'h30, '0, 1, 0, 32'h3C, '0);
      n_ack += int'(c_ack_o); n_rv += int'(l_rvalid_o); n_rdy += int'(l_ready_o);
    end
    checkOutput("rdwait_one_ack", n_ack, 1);
    checkOutput("rdwait_no_rvalid", n_rv, 0);
    checkOutput("rdwait_no_ready", n_rdy, 0);
    applyStimulus(0, 0, 0, '0, '0, 1, 0, 32'h3C, '0);
    checkOutput("ldr_after_rdwait", l_ready_o, 1);
    for (int i = 0; i < RL + 1; i++) idleCycle();

    // Reset one cycle after a core read issue drops the read.
    applyStimulus(0, 1, 0, 32'h10, '0, 0, 0, '0, '0);
    applyStimulus(1, 1, 0, 32'h10, '0, 0, 0, '0, '0);
    n_ack = 0;
    for (int i = 0; i < RL + 2; i++) begin
      idleCycle();
      n_ack += int'(c_ack_o);
    end
    checkOutput("reset_drops_read", n_ack, 0);

    for (int i = 0; i < 3000; i++) randomStep(60, 50);
    for (int i = 0; i < RL + 2; i++) idleCycle();

`ifdef DMEM_ARB_STATS_EN
    for (int i = 0; i < 80000 && mdl_stall < 65535; i++)
      applyStimulus(0, !last_core_ack, 0, 32'h10, '0, 0, 0, '0, '0);
    for (int i = 0; i < 4; i++)
      applyStimulus(0, !last_core_ack, 0, 32'h10, '0, 0, 0, '0, '0);
    checkOutput("stall_saturated", stall_cycles_o, 32'hFFFF);
    for (int i = 0; i < RL + 2; i++) idleCycle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
